// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: divider FSM states, data width and the
// Z-register (RZHI/RZLO) half-select constants.
package cpu_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned Z_W     = 2 * DATA_W;

   // Z-register half selects: RZHI = result[ZHI_MSB:ZHI_LSB], RZLO = result[ZLO_MSB:ZLO_LSB]
   localparam int unsigned ZHI_MSB = Z_W - 1;
   localparam int unsigned ZHI_LSB = DATA_W;
   localparam int unsigned ZLO_MSB = DATA_W - 1;
   localparam int unsigned ZLO_LSB = 0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step, MSB first.
// Ports:
//   r, q   : partial remainder and quotient/dividend shift register
//   d      : divisor magnitude (non-zero)
//   r_next : partial remainder after the step
//   q_next : shift register after the step, new quotient bit in q_next[0]
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] r_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0] r_sh;
   logic [WIDTH:0] diff;
   logic           fits;

   always_comb begin
      r_sh = {r, q[WIDTH-1]};
      diff = r_sh - {1'b0, d};
      // A set top bit of the shifted remainder already exceeds any divisor;
      // otherwise the subtract's top bit is the borrow.
      fits = r_sh[WIDTH] | ~diff[WIDTH];
      if (fits) begin
         r_next = diff[WIDTH-1:0];
         q_next = {q[WIDTH-2:0], 1'b1};
      end else begin
         r_next = r_sh[WIDTH-1:0];
         q_next = {q[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV; result feeds the Z register.
// Optional macro: SEQ_DIVIDER_EARLY_EXIT_EN skips the iterations when
// |divisor| > |dividend|.
// Ports:
//   clk         : clock, rising edge
//   clear       : synchronous active-high reset
//   start       : request, sampled only in IDLE
//   is_signed   : 1 = signed divide, latched with start
//   dividend    : RY value, latched with start
//   divisor     : bus value, latched with start
//   result      : {remainder, quotient}
//   finished    : one-cycle pulse, result valid from this cycle
//   busy        : operation in progress
//   div_by_zero : divisor was zero, held until next accepted start
module seq_divider
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned CNT_W = 6
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic [2*WIDTH-1:0] result,
   output logic               finished,
   output logic               busy,
   output logic               div_by_zero
);

   div_state_t         state, state_n;
   logic [WIDTH-1:0]   op_a, op_a_n, op_b, op_b_n;
   logic               sgn, sgn_n;
   logic [WIDTH-1:0]   rem, rem_n, quo, quo_n, dmag, dmag_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               q_neg, q_neg_n, r_neg, r_neg_n;
   logic [2*WIDTH-1:0] result_n;
   logic               finished_n, busy_n, dbz_n;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b, step_r, step_q, fix_r, fix_q;

   // Operand magnitudes and sign-corrected results
   always_comb begin
      a_neg = sgn & op_a[WIDTH-1];
      b_neg = sgn & op_b[WIDTH-1];
      mag_a = a_neg ? (WIDTH'(0) - op_a) : op_a;
      mag_b = b_neg ? (WIDTH'(0) - op_b) : op_b;
      fix_r = r_neg ? (WIDTH'(0) - rem) : rem;
      fix_q = q_neg ? (WIDTH'(0) - quo) : quo;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (rem),
      .q      (quo),
      .d      (dmag),
      .r_next (step_r),
      .q_next (step_q)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_n    = state;
      op_a_n     = op_a;
      op_b_n     = op_b;
      sgn_n      = sgn;
      rem_n      = rem;
      quo_n      = quo;
      dmag_n     = dmag;
      cnt_n      = cnt;
      q_neg_n    = q_neg;
      r_neg_n    = r_neg;
      result_n   = result;
      dbz_n      = div_by_zero;
      finished_n = (state == DONE);

      case (state)
         IDLE: begin
            if (start) begin
               op_a_n  = dividend;
               op_b_n  = divisor;
               sgn_n   = is_signed;
               dbz_n   = 1'b0;
               state_n = PREP;
            end
         end
         PREP: begin
            if (op_b == '0) begin
               result_n = {op_a, {WIDTH{1'b1}}};
               dbz_n    = 1'b1;
               state_n  = DONE;
            end else begin
               rem_n   = '0;
               quo_n   = mag_a;
               dmag_n  = mag_b;
               cnt_n   = '0;
               q_neg_n = a_neg ^ b_neg;
               r_neg_n = a_neg;
               state_n = ITER;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
               // Quotient is zero; FIX passes the original dividend through.
               if (mag_b > mag_a) begin
                  rem_n   = op_a;
                  quo_n   = '0;
                  q_neg_n = 1'b0;
                  r_neg_n = 1'b0;
                  state_n = FIX;
               end
`endif
            end
         end
         ITER: begin
            rem_n = step_r;
            quo_n = step_q;
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_n = FIX;
            end
         end
         FIX: begin
            result_n = {fix_r, fix_q};
            state_n  = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (clear) begin
         state       <= IDLE;
         op_a        <= '0;
         op_b        <= '0;
         sgn         <= 1'b0;
         rem         <= '0;
         quo         <= '0;
         dmag        <= '0;
         cnt         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         result      <= '0;
         finished    <= 1'b0;
         busy        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_n;
         op_a        <= op_a_n;
         op_b        <= op_b_n;
         sgn         <= sgn_n;
         rem         <= rem_n;
         quo         <= quo_n;
         dmag        <= dmag_n;
         cnt         <= cnt_n;
         q_neg       <= q_neg_n;
         r_neg       <= r_neg_n;
         result      <= result_n;
         finished    <= finished_n;
         busy        <= busy_n;
         div_by_zero <= dbz_n;
      end
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider for the DIV instruction.
- Sits in the ALU stage directly upstream of the 64-bit Z register (RZHI/RZLO).
- Consumes the Y register value (dividend) and the bus value (divisor) on start.
- Produces {remainder, quotient} and raises finished when Z may be loaded.
- Uses the same start/finished handshake the datapath ALU already exposes.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clock  in  1  single clock; all state changes on rising edge.
- clear  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = signed divide, 0 = unsigned; latched with start.
- dividend  in  WIDTH  from RY; latched with start.
- divisor  in  WIDTH  from bus; latched with start.
- result  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; high half goes to RZHI, low half to RZLO.
- finished  out  1  one-cycle pulse; result is valid from this cycle.
- busy  out  1  high from the cycle after start is sampled until finished.
- div_by_zero  out  1  set with finished when divisor == 0; held until the next accepted start.

Behaviour:
- Reset (clear=1 at an edge): state=IDLE; result=0; finished=0; busy=0; div_by_zero=0; counter=0.
- Reset applied mid-operation aborts the operation. No finished pulse is produced for the aborted operation.
- IDLE: on start=1, latch operands and is_signed, clear div_by_zero, go to PREP. Otherwise stay in IDLE.
- PREP (1 cycle):
  - If divisor==0: result={dividend, all ones}, div_by_zero=1, go to DONE.
  - Else: take magnitudes (two's-complement negate if is_signed and MSB set), record quotient sign (sign(a) XOR sign(b)) and remainder sign (sign(a)), load partial remainder=0, counter=0, go to ITER.
- ITER (exactly WIDTH cycles): one restoring step per cycle, MSB first.
  - Shift {R,Q} left by 1.
  - Trial R-|divisor| uses a WIDTH+1-bit subtract.
  - If non-negative, keep the difference and set Q[0]=1.
  - After the step with counter==WIDTH-1, go to FIX.
- FIX (1 cycle): negate quotient and/or remainder per the recorded signs (signed only). Write result. Go to DONE.
- DONE (1 cycle): finished=1, busy=0, go to IDLE. result holds until the next accepted start completes FIX or PREP.
- Latency:
  - Normal: finished is high exactly WIDTH+3 cycles after the edge that sampled start (35 for WIDTH=32).
  - Divide by zero: finished is high 2 cycles after that edge.
- start while busy is ignored and does not re-latch operands. start held high through DONE is accepted again in the following IDLE cycle.
- Signed semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Most-negative / -1 wraps: quotient=0x80000000, remainder=0, no flag.
- Unsigned: all bits are magnitude; no sign correction in FIX.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_EXIT_EN.
- With the macro: in PREP, if |divisor| > |dividend| (unsigned compare of magnitudes, divisor≠0), skip ITER. FIX writes quotient=0, remainder=dividend (original signed value). finished arrives 3 cycles after the start edge.
- Without the macro: always exactly WIDTH iterations, so latency is fixed at WIDTH+3.

Decomposition:
- Shared package cpu_pkg:
  - div_state_t enum (IDLE, PREP, ITER, FIX, DONE).
  - DATA_W=32 constant.
  - Z-register half-select constants used by the datapath.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs R, Q, D; outputs R', Q'.
  - Instantiated once inside the ITER datapath.

Test Plan:
- Unsigned 100 / 7, start one cycle → finished exactly 35 cycles later; result={0x00000002, 0x0000000E}; div_by_zero=0.
- Signed -100 / 7 → result={0xFFFFFFFE, 0xFFFFFFF2}. Signed 100 / -7 → result={0x00000002, 0xFFFFFFF2}.
- Divisor 0, dividend 7 → finished 2 cycles after start; result={0x00000007, 0xFFFFFFFF}; div_by_zero=1, cleared on the next start.
- Signed 0x80000000 / 0xFFFFFFFF → result={0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Start 100/7, pulse start with 9/3 at cycle 10, then assert clear at cycle 20 → the second start is ignored; after clear all outputs are 0 and no finished pulse occurs. A fresh 9/3 then gives {0, 3} at 35 cycles.
- With SEQ_DIVIDER_EARLY_EXIT_EN, 5 / 9 → finished 3 cycles after start, result={0x00000005, 0}. Without the macro, the same result arrives at 35 cycles.
